// File: rtl/elevator_pkg.sv
// Shared parameters, state encoding and the direction-decision helper for the
// elevator request scheduler.
package elevator_pkg;

    localparam int N_FLOORS    = 5;
    localparam int FLOOR_W     = 3;
    localparam int DOOR_CYCLES = 1000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } sched_state_t;

    typedef logic [FLOOR_W-1:0] floor_t;

    // SCAN choice: with work on both sides keep the current direction.
    function automatic sched_state_t decide(input logic above, input logic below,
                                            input logic dir_up);
        if (above && below) begin
            return dir_up ? MOVE_UP : MOVE_DOWN;
        end else if (above) begin
            return MOVE_UP;
        end else if (below) begin
            return MOVE_DOWN;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/door_timer.sv
// Door dwell counter: loads on door entry or reload, counts down while the door
// is open, and flags expiry when it reaches zero without a reload.
module door_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic load_i,
    output logic expiry_o
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(CYCLES - 1);
        end else if (active_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A reload in the expiry cycle wins, so the pulse is suppressed.
    assign expiry_o = active_i && !load_i && (count_q == '0);

endmodule

// File: rtl/elevator_request_scheduler.sv
// Floor-request latch, car position tracking and SCAN direction FSM driving
// the motion controller and the door timer.
module elevator_request_scheduler #(
    parameter int N_FLOORS    = elevator_pkg::N_FLOORS,
    parameter int FLOOR_W     = elevator_pkg::FLOOR_W,
    parameter int DOOR_CYCLES = elevator_pkg::DOOR_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] floor_req,
    input  logic                floor_step,
    input  logic                door_hold,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic                solicitud,
    output logic                move_up,
    output logic                move_down,
    output logic                door_open,
    output logic                time_expired
);

    import elevator_pkg::*;

    sched_state_t        state_q, state_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic                dir_up_q, dir_up_d;
    logic                expired_q;

    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] onehot_cur, onehot_new, above_cur, below_cur, above_new, below_new;
    logic [N_FLOORS-1:0] latch_mask, clear_vec;
    logic                at_top, at_bot, step_ok, req_here, arrive_stop, enter_door;
    logic                in_door, timer_load, expiry;

    assign at_top     = (floor_q == FLOOR_W'(N_FLOORS - 1));
    assign at_bot     = (floor_q == '0);
    assign next_floor = (state_q == MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
    assign step_ok    = floor_step && (((state_q == MOVE_UP) && !at_top) ||
                                       ((state_q == MOVE_DOWN) && !at_bot));

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_floor
        assign onehot_cur[gi] = (floor_q == FLOOR_W'(gi));
        assign onehot_new[gi] = (next_floor == FLOOR_W'(gi));
        assign above_cur[gi]  = pending_q[gi] && (floor_q < FLOOR_W'(gi));
        assign below_cur[gi]  = pending_q[gi] && (floor_q > FLOOR_W'(gi));
        assign above_new[gi]  = pending_q[gi] && (next_floor < FLOOR_W'(gi));
        assign below_new[gi]  = pending_q[gi] && (next_floor > FLOOR_W'(gi));
    end

    assign req_here    = |(floor_req & onehot_cur);
    assign arrive_stop = step_ok && |(pending_q & onehot_new);
    assign enter_door  = ((state_q == IDLE) && req_here) || arrive_stop;
    assign in_door     = (state_q == DOOR);
    assign timer_load  = enter_door || (in_door && (door_hold || req_here));

    door_timer #(
        .CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk      (clk),
        .rst_n    (reset),
        .active_i (in_door),
        .load_i   (timer_load),
        .expiry_o (expiry)
    );

    // A stopped car answers a button at its own floor by opening the door instead.
    assign latch_mask = ((state_q == IDLE) || in_door) ? onehot_cur : '0;
    assign clear_vec  = arrive_stop ? onehot_new : '0;
    assign pending_d  = (pending_q | (floor_req & ~latch_mask)) & ~clear_vec;

    always_comb begin
        state_d = state_q;
        floor_d = step_ok ? next_floor : floor_q;
        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d = DOOR;
                end else begin
                    state_d = decide(|above_cur, |below_cur, dir_up_q);
                end
            end
            MOVE_UP: begin
                if (arrive_stop) begin
                    state_d = DOOR;
                end else if (step_ok && !(|above_new)) begin
                    state_d = decide(1'b0, |below_new, dir_up_q);
                end
            end
            MOVE_DOWN: begin
                if (arrive_stop) begin
                    state_d = DOOR;
                end else if (step_ok && !(|below_new)) begin
                    state_d = decide(|above_new, 1'b0, dir_up_q);
                end
            end
            DOOR: begin
                if (expiry) begin
                    state_d = decide(|above_cur, |below_cur, dir_up_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dir_up_d = dir_up_q;
        if (state_d == MOVE_UP) begin
            dir_up_d = 1'b1;
        end else if (state_d == MOVE_DOWN) begin
            dir_up_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            expired_q <= expiry;
        end
    end

    assign pending       = pending_q;
    assign current_floor = floor_q;
    assign move_up       = (state_q == MOVE_UP);
    assign move_down     = (state_q == MOVE_DOWN);
    assign door_open     = in_door;
    assign solicitud     = (|pending_q) || move_up || move_down;
    assign time_expired  = expired_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the elevator request scheduler with an 8-cycle door timer.
module tb_elevator_request_scheduler;

    localparam int N  = 5;
    localparam int FW = 3;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  floor_req;
    logic          floor_step;
    logic          door_hold;
    logic [N-1:0]  pending;
    logic [FW-1:0] current_floor;
    logic          solicitud, move_up, move_down, door_open, time_expired;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    elevator_request_scheduler #(
        .N_FLOORS    (N),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .floor_req     (floor_req),
        .floor_step    (floor_step),
        .door_hold     (door_hold),
        .pending       (pending),
        .current_floor (current_floor),
        .solicitud     (solicitud),
        .move_up       (move_up),
        .move_down     (move_down),
        .door_open     (door_open),
        .time_expired  (time_expired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_pulse();
        floor_step = 1'b1;
        tick(1);
        floor_step = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] req);
        floor_req = req;
        tick(1);
        floor_req = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        floor_req  = '0;
        floor_step = 1'b0;
        door_hold  = 1'b0;
        do_reset();
        check_eq("rst_floor", 32'(current_floor), 32'd0);
        check_eq("rst_solic", 32'(solicitud), 32'd0);

        // 1: asynchronous reset in the middle of a door cycle
        press(5'b00001);
        check_eq("t1_door", 32'(door_open), 32'd1);
        press(5'b10110);
        check_eq("t1_pend", 32'(pending), 32'h16);
        reset = 1'b0;
        #1;
        check_eq("t1_rst_pend", 32'(pending), 32'd0);
        check_eq("t1_rst_outs", 32'({solicitud, move_up, move_down, door_open, time_expired}), 32'd0);
        check_eq("t1_rst_floor", 32'(current_floor), 32'd0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // 2: idle at 0, request floor 3
        press(5'b01000);
        check_eq("t2_latch", 32'(pending), 32'h08);
        check_eq("t2_up_early", 32'(move_up), 32'd0);
        tick(1);
        check_eq("t2_up", 32'(move_up), 32'd1);
        check_eq("t2_solic", 32'(solicitud), 32'd1);
        step_pulse();
        check_eq("t2_f1", 32'(current_floor), 32'd1);
        step_pulse();
        step_pulse();
        check_eq("t2_f3", 32'(current_floor), 32'd3);
        check_eq("t2_door", 32'(door_open), 32'd1);
        check_eq("t2_pend0", 32'(pending), 32'd0);
        tick(7);
        check_eq("t2_no_exp", 32'(time_expired), 32'd0);
        tick(1);
        check_eq("t2_exp", 32'(time_expired), 32'd1);
        check_eq("t2_closed", 32'(door_open), 32'd0);
        tick(1);
        check_eq("t2_exp_1cyc", 32'(time_expired), 32'd0);
        check_eq("t2_idle_solic", 32'(solicitud), 32'd0);

        // 3: going up at floor 2 with requests at 0 and 4
        do_reset();
        press(5'b10000);
        tick(1);
        step_pulse();
        step_pulse();
        press(5'b00001);
        check_eq("t3_pend", 32'(pending), 32'h11);
        step_pulse();
        check_eq("t3_f3", 32'(current_floor), 32'd3);
        check_eq("t3_still_up", 32'(move_up), 32'd1);
        step_pulse();
        check_eq("t3_f4", 32'(current_floor), 32'd4);
        check_eq("t3_door4", 32'(door_open), 32'd1);
        check_eq("t3_pend_left", 32'(pending), 32'h01);

        // 6: a stray step at the top floor does not move the car
        step_pulse();
        check_eq("t6_top_sat", 32'(current_floor), 32'd4);
        tick(6);
        tick(1);
        check_eq("t3_exp", 32'(time_expired), 32'd1);
        check_eq("t3_down", 32'(move_down), 32'd1);
        for (int i = 0; i < 4; i++) step_pulse();
        check_eq("t3_f0", 32'(current_floor), 32'd0);
        check_eq("t3_door0", 32'(door_open), 32'd1);
        check_eq("t3_pend0", 32'(pending), 32'd0);
        check_eq("t3_down_off", 32'(move_down), 32'd0);

        // 4: door held for 20 cycles
        door_hold = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (time_expired) pulses++;
        end
        door_hold = 1'b0;
        check_eq("t4_no_pulse", 32'(pulses), 32'd0);
        check_eq("t4_held_open", 32'(door_open), 32'd1);
        tick(7);
        check_eq("t4_no_exp", 32'(time_expired), 32'd0);
        tick(1);
        check_eq("t4_exp", 32'(time_expired), 32'd1);

        // 5: own-floor request during the door cycle reloads the timer
        tick(1);
        press(5'b00001);
        check_eq("t5_door", 32'(door_open), 32'd1);
        tick(4);
        press(5'b00001);
        check_eq("t5_pend0", 32'(pending), 32'd0);
        tick(3);
        check_eq("t5_no_exp_a", 32'(time_expired), 32'd0);
        check_eq("t5_still_open", 32'(door_open), 32'd1);
        tick(4);
        check_eq("t5_no_exp_b", 32'(time_expired), 32'd0);
        tick(1);
        check_eq("t5_exp", 32'(time_expired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
